// File: rtl/axi_full_slave_sram.sv
// AXI4 slave over a flat SRAM: one burst per direction, first read beat 1 cycle after AR, beats back-to-back while RREADY=1.
// Stalls hold RDATA/RID; WRAP bursts wrap only with AXI_SRAM_WRAP_BURST_EN defined, otherwise they run as INCR.
module axi_full_slave_sram_mem #(
   parameter int DW = 128,
   parameter int AW = 14
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [DW/8-1:0] wstrb,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rword
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] ram [0:DEPTH-1];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < DW/8; b++) begin
            if (wstrb[b]) ram[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rword = ram[raddr];
endmodule

module axi_full_slave_sram #(
   parameter int DW = 128,
   parameter int AW = 14,
   parameter int IW = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [IW-1:0]   MEM_AWID,
   input  logic [31:0]     MEM_AWADDR,
   input  logic [7:0]      MEM_AWLEN,
   input  logic [2:0]      MEM_AWSIZE,
   input  logic [1:0]      MEM_AWBURST,
   input  logic            MEM_AWVALID,
   output logic            MEM_AWREADY,
   input  logic [DW-1:0]   MEM_WDATA,
   input  logic [DW/8-1:0] MEM_WSTRB,
   input  logic            MEM_WLAST,
   input  logic            MEM_WVALID,
   output logic            MEM_WREADY,
   output logic [IW-1:0]   MEM_BID,
   output logic [1:0]      MEM_BRESP,
   output logic            MEM_BVALID,
   input  logic            MEM_BREADY,
   input  logic [IW-1:0]   MEM_ARID,
   input  logic [31:0]     MEM_ARADDR,
   input  logic [7:0]      MEM_ARLEN,
   input  logic [2:0]      MEM_ARSIZE,
   input  logic [1:0]      MEM_ARBURST,
   input  logic            MEM_ARVALID,
   output logic            MEM_ARREADY,
   output logic [IW-1:0]   MEM_RID,
   output logic [DW-1:0]   MEM_RDATA,
   output logic [1:0]      MEM_RRESP,
   output logic            MEM_RLAST,
   output logic            MEM_RVALID,
   input  logic            MEM_RREADY
);
   localparam int OFF = $clog2(DW/8);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [IW-1:0] aw_id, ar_id;
   logic [31:0]   aw_addr, ar_addr, w_adv, r_adv;
   logic [2:0]    aw_size, ar_size;
   logic [1:0]    aw_burst, ar_burst;
   logic [7:0]    ar_len, r_beat;
   logic [DW-1:0] rdata, rword;
   logic [AW-1:0] raddr;
   logic          aw_hs, w_hs, ar_hs, r_hs;

`ifdef AXI_SRAM_WRAP_BURST_EN
   logic [7:0]    aw_len;

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] step, mask;
      step = 32'd1 << size;
      mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
      if (burst == 2'b00) return addr;
      if (burst == 2'b10) return (addr & ~mask) | ((addr + step) & mask);
      return addr + step;
   endfunction

   assign w_adv = next_addr(aw_addr, aw_len, aw_size, aw_burst);
   assign r_adv = next_addr(ar_addr, ar_len, ar_size, ar_burst);
`else
   logic unused_awlen;

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                             input logic [1:0] burst);
      if (burst == 2'b00) return addr;
      return addr + (32'd1 << size);
   endfunction

   assign unused_awlen = ^MEM_AWLEN;
   assign w_adv = next_addr(aw_addr, aw_size, aw_burst);
   assign r_adv = next_addr(ar_addr, ar_size, ar_burst);
`endif

   // Outputs are forced low while reset is high, so the readies rise only once reset drops.
   always_comb begin
      w_next      = w_state;
      r_next      = r_state;
      MEM_AWREADY = 1'b0;
      MEM_WREADY  = 1'b0;
      MEM_BVALID  = 1'b0;
      MEM_ARREADY = 1'b0;
      MEM_RVALID  = 1'b0;
      MEM_RLAST   = 1'b0;
      if (!reset) begin
         case (w_state)
            W_IDLE: begin
               MEM_AWREADY = 1'b1;
               if (MEM_AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
               MEM_WREADY = 1'b1;
               if (MEM_WVALID && MEM_WLAST) w_next = W_RESP;
            end
            W_RESP: begin
               MEM_BVALID = 1'b1;
               if (MEM_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
         endcase
         case (r_state)
            R_IDLE: begin
               MEM_ARREADY = 1'b1;
               if (MEM_ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
               MEM_RVALID = 1'b1;
               MEM_RLAST  = (r_beat == ar_len);
               if (MEM_RREADY && MEM_RLAST) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
         endcase
      end
   end

   assign aw_hs = MEM_AWVALID && MEM_AWREADY;
   assign w_hs  = MEM_WVALID && MEM_WREADY;
   assign ar_hs = MEM_ARVALID && MEM_ARREADY;
   assign r_hs  = MEM_RVALID && MEM_RREADY;

   // In idle the read port looks at the incoming ARADDR; mid-burst it looks one beat ahead.
   assign raddr = (r_state == R_IDLE) ? MEM_ARADDR[AW+OFF-1:OFF] : r_adv[AW+OFF-1:OFF];

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state  <= W_IDLE;
         r_state  <= R_IDLE;
         aw_id    <= '0;
         aw_addr  <= '0;
         aw_size  <= '0;
         aw_burst <= '0;
`ifdef AXI_SRAM_WRAP_BURST_EN
         aw_len   <= '0;
`endif
         ar_id    <= '0;
         ar_addr  <= '0;
         ar_len   <= '0;
         ar_size  <= '0;
         ar_burst <= '0;
         r_beat   <= '0;
         rdata    <= '0;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
         if (aw_hs) begin
            aw_id    <= MEM_AWID;
            aw_addr  <= MEM_AWADDR;
            aw_size  <= MEM_AWSIZE;
            aw_burst <= MEM_AWBURST;
`ifdef AXI_SRAM_WRAP_BURST_EN
            aw_len   <= MEM_AWLEN;
`endif
         end
         if (w_hs) aw_addr <= w_adv;
         if (ar_hs) begin
            ar_id    <= MEM_ARID;
            ar_addr  <= MEM_ARADDR;
            ar_len   <= MEM_ARLEN;
            ar_size  <= MEM_ARSIZE;
            ar_burst <= MEM_ARBURST;
            r_beat   <= '0;
            rdata    <= rword;
         end else if (r_hs && !MEM_RLAST) begin
            ar_addr <= r_adv;
            r_beat  <= r_beat + 8'd1;
            rdata   <= rword;
         end
      end
   end

   axi_full_slave_sram_mem #(.DW(DW), .AW(AW)) i_sram (
      .clock (clock),
      .we    (w_hs),
      .waddr (aw_addr[AW+OFF-1:OFF]),
      .wdata (MEM_WDATA),
      .wstrb (MEM_WSTRB),
      .raddr (raddr),
      .rword (rword)
   );

   assign MEM_BID   = aw_id;
   assign MEM_BRESP = 2'b00;
   assign MEM_RID   = ar_id;
   assign MEM_RDATA = rdata;
   assign MEM_RRESP = 2'b00;
endmodule

// File: tb/tb_axi_full_slave_sram.sv
// Directed bench for axi_full_slave_sram: reset, single/strobed writes, INCR/FIXED/WRAP reads, stalls, overlap, mid-burst reset.
module tb_axi_full_slave_sram;
   localparam int DW = 128;
   localparam int AW = 14;
   localparam int IW = 8;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [IW-1:0]   MEM_AWID = '0;
   logic [31:0]     MEM_AWADDR = '0;
   logic [7:0]      MEM_AWLEN = '0;
   logic [2:0]      MEM_AWSIZE = '0;
   logic [1:0]      MEM_AWBURST = '0;
   logic            MEM_AWVALID = 1'b0;
   logic            MEM_AWREADY;
   logic [DW-1:0]   MEM_WDATA = '0;
   logic [DW/8-1:0] MEM_WSTRB = '0;
   logic            MEM_WLAST = 1'b0;
   logic            MEM_WVALID = 1'b0;
   logic            MEM_WREADY;
   logic [IW-1:0]   MEM_BID;
   logic [1:0]      MEM_BRESP;
   logic            MEM_BVALID;
   logic            MEM_BREADY = 1'b0;
   logic [IW-1:0]   MEM_ARID = '0;
   logic [31:0]     MEM_ARADDR = '0;
   logic [7:0]      MEM_ARLEN = '0;
   logic [2:0]      MEM_ARSIZE = '0;
   logic [1:0]      MEM_ARBURST = '0;
   logic            MEM_ARVALID = 1'b0;
   logic            MEM_ARREADY;
   logic [IW-1:0]   MEM_RID;
   logic [DW-1:0]   MEM_RDATA;
   logic [1:0]      MEM_RRESP;
   logic            MEM_RLAST;
   logic            MEM_RVALID;
   logic            MEM_RREADY = 1'b0;

   int errs = 0;
   int checks = 0;

   axi_full_slave_sram #(.DW(DW), .AW(AW), .IW(IW)) dut (
      .clock(clock), .reset(reset),
      .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN), .MEM_AWSIZE(MEM_AWSIZE),
      .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
      .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST), .MEM_WVALID(MEM_WVALID),
      .MEM_WREADY(MEM_WREADY), .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID),
      .MEM_BREADY(MEM_BREADY), .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
      .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID),
      .MEM_ARREADY(MEM_ARREADY), .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP),
      .MEM_RLAST(MEM_RLAST), .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic aw_req(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
      int n;
      MEM_AWID = id; MEM_AWADDR = addr; MEM_AWLEN = len; MEM_AWSIZE = 3'd4; MEM_AWBURST = burst;
      MEM_AWVALID = 1'b1;
      n = 0;
      while (!MEM_AWREADY && n < 20) begin tick(); n++; end
      chk("aw_ready", MEM_AWREADY, 1);
      tick();
      MEM_AWVALID = 1'b0;
   endtask

   task automatic ar_req(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
      int n;
      MEM_ARID = id; MEM_ARADDR = addr; MEM_ARLEN = len; MEM_ARSIZE = 3'd4; MEM_ARBURST = burst;
      MEM_ARVALID = 1'b1;
      n = 0;
      while (!MEM_ARREADY && n < 20) begin tick(); n++; end
      chk("ar_ready", MEM_ARREADY, 1);
      tick();
      MEM_ARVALID = 1'b0;
   endtask

   task automatic w_beat(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
      int n;
      MEM_WDATA = data; MEM_WSTRB = strb; MEM_WLAST = last; MEM_WVALID = 1'b1;
      n = 0;
      while (!MEM_WREADY && n < 20) begin tick(); n++; end
      chk("w_ready", MEM_WREADY, 1);
      tick();
      MEM_WVALID = 1'b0;
   endtask

   task automatic wr_single(input logic [IW-1:0] id, input logic [31:0] addr,
                            input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
      aw_req(id, addr, 8'd0, 2'b01);
      w_beat(data, strb, 1'b1);
      chk("bvalid", MEM_BVALID, 1);
      chk("bid", MEM_BID, id);
      chk("bresp", MEM_BRESP, 0);
      MEM_BREADY = 1'b1;
      tick();
      MEM_BREADY = 1'b0;
      chk("bvalid_done", MEM_BVALID, 0);
   endtask

   task automatic rd_burst(input string tag, input logic [IW-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [DW-1:0] exp [4], input logic stall);
      ar_req(id, addr, len, burst);
      for (int i = 0; i <= int'(len); i++) begin
         if (stall) begin
            MEM_RREADY = 1'b0;
            tick();
            chk($sformatf("%s_hold_v%0d", tag, i), MEM_RVALID, 1);
            chk($sformatf("%s_hold_d%0d", tag, i), MEM_RDATA, exp[i]);
         end
         MEM_RREADY = 1'b1;
         chk($sformatf("%s_v%0d", tag, i), MEM_RVALID, 1);
         chk($sformatf("%s_d%0d", tag, i), MEM_RDATA, exp[i]);
         chk($sformatf("%s_last%0d", tag, i), MEM_RLAST, (i == int'(len)) ? 1 : 0);
         chk($sformatf("%s_id%0d", tag, i), MEM_RID, id);
         chk($sformatf("%s_resp%0d", tag, i), MEM_RRESP, 0);
         tick();
      end
      MEM_RREADY = 1'b0;
      chk($sformatf("%s_end", tag), MEM_RVALID, 0);
   endtask

   initial begin
      logic [DW-1:0] exp [4];
      logic [DW-1:0] pat;
      logic [DW/8-1:0] ones;
      ones = '1;
      pat  = 128'h00112233445566778899AABBCCDDEEFF;

      // reset and idle
      tick(); tick();
      chk("rst_awready", MEM_AWREADY, 0);
      chk("rst_arready", MEM_ARREADY, 0);
      chk("rst_rdata", MEM_RDATA, 0);
      reset = 1'b0;
      tick();
      chk("idle_awready", MEM_AWREADY, 1);
      chk("idle_arready", MEM_ARREADY, 1);
      chk("idle_rvalid", MEM_RVALID, 0);
      chk("idle_bvalid", MEM_BVALID, 0);

      // single write at aliased address, read back
      wr_single(8'h0A, 32'h8000_0010, pat, ones);
      chk("ram1", dut.i_sram.ram[1], pat);
      exp[0] = pat; exp[1] = '0; exp[2] = '0; exp[3] = '0;
      rd_burst("single", 8'h05, 32'h8000_0010, 8'd0, 2'b01, exp, 1'b0);

      // byte strobe
      dut.i_sram.ram[5] = '1;
      wr_single(8'h11, 32'h0000_0050, 128'hAB, 16'h0001);
      exp[0] = {{120{1'b1}}, 8'hAB};
      rd_burst("strb", 8'h22, 32'h0000_0050, 8'd0, 2'b01, exp, 1'b0);

      // INCR, stalled INCR, FIXED
      for (int i = 0; i < 6; i++) dut.i_sram.ram[i] = DW'(i + 1);
      for (int i = 0; i < 4; i++) exp[i] = DW'(i + 1);
      rd_burst("incr", 8'h01, 32'h0, 8'd3, 2'b01, exp, 1'b0);
      rd_burst("stall", 8'h02, 32'h0, 8'd3, 2'b01, exp, 1'b1);
      exp[0] = 4; exp[1] = 4;
      rd_burst("fixed", 8'h03, 32'h30, 8'd1, 2'b00, exp, 1'b0);

      // WRAP
`ifdef AXI_SRAM_WRAP_BURST_EN
      exp[0] = 3; exp[1] = 4; exp[2] = 1; exp[3] = 2;
`else
      exp[0] = 3; exp[1] = 4; exp[2] = 5; exp[3] = 6;
`endif
      rd_burst("wrap", 8'h04, 32'h20, 8'd3, 2'b10, exp, 1'b0);

      // overlapping read and write bursts
      MEM_AWID = 8'h0A; MEM_AWADDR = 32'h100; MEM_AWLEN = 8'd3; MEM_AWSIZE = 3'd4; MEM_AWBURST = 2'b01;
      MEM_ARID = 8'h05; MEM_ARADDR = 32'h0;   MEM_ARLEN = 8'd3; MEM_ARSIZE = 3'd4; MEM_ARBURST = 2'b01;
      MEM_AWVALID = 1'b1; MEM_ARVALID = 1'b1;
      chk("ov_awready", MEM_AWREADY, 1);
      chk("ov_arready", MEM_ARREADY, 1);
      tick();
      MEM_AWVALID = 1'b0; MEM_ARVALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         MEM_WVALID = 1'b1; MEM_WDATA = DW'(8'hA0 + i); MEM_WSTRB = ones; MEM_WLAST = (i == 3);
         MEM_RREADY = 1'b1;
         chk($sformatf("ov_wready%0d", i), MEM_WREADY, 1);
         chk($sformatf("ov_rvalid%0d", i), MEM_RVALID, 1);
         chk($sformatf("ov_rdata%0d", i), MEM_RDATA, DW'(i + 1));
         chk($sformatf("ov_rlast%0d", i), MEM_RLAST, (i == 3) ? 1 : 0);
         chk($sformatf("ov_rid%0d", i), MEM_RID, 8'h05);
         tick();
      end
      MEM_WVALID = 1'b0; MEM_WLAST = 1'b0; MEM_RREADY = 1'b0;
      chk("ov_rdone", MEM_RVALID, 0);
      chk("ov_bvalid", MEM_BVALID, 1);
      chk("ov_bid", MEM_BID, 8'h0A);
      MEM_BREADY = 1'b1;
      tick();
      MEM_BREADY = 1'b0;
      for (int i = 0; i < 4; i++) chk($sformatf("ov_ram%0d", i), dut.i_sram.ram[16 + i], DW'(8'hA0 + i));

      // reset in the middle of both bursts
      ar_req(8'h07, 32'h0, 8'd3, 2'b01);
      aw_req(8'h08, 32'h200, 8'd3, 2'b01);
      w_beat(128'h55, ones, 1'b0);
      MEM_RREADY = 1'b1;
      tick();
      MEM_RREADY = 1'b0;
      chk("mid_rvalid", MEM_RVALID, 1);
      chk("mid_wready", MEM_WREADY, 1);
      reset = 1'b1;
      tick();
      chk("mrst_rvalid", MEM_RVALID, 0);
      chk("mrst_wready", MEM_WREADY, 0);
      reset = 1'b0;
      tick();
      chk("mrst_awready", MEM_AWREADY, 1);
      chk("mrst_arready", MEM_ARREADY, 1);
      chk("mrst_rvalid2", MEM_RVALID, 0);
      chk("mrst_ram32", dut.i_sram.ram[32], 128'h55);
      chk("mrst_ram0", dut.i_sram.ram[0], 1);
      chk("mrst_ram16", dut.i_sram.ram[16], 128'hA0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/axi_full_slave_sram.md
Name: axi_full_slave_sram

Overview:
- AXI4 full-protocol slave wrapping a single-port-per-channel SRAM; the main-memory model behind the core's memory AXI port in chip-level simulation.
- Independent read and write FSMs; one outstanding transaction per direction; bursts supported.
- The storage array is back-door loadable by benches at hierarchy i_sram.ram.

Parameters:
- DW, 128, data width in bits (multiple of 8, power of 2).
- AW, 14, word-address width; depth = 2^AW words of DW bits.
- IW, 8, AXI ID width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MEM_AWID in IW; MEM_AWADDR in 32; MEM_AWLEN in 8; MEM_AWSIZE in 3; MEM_AWBURST in 2; MEM_AWVALID in 1; MEM_AWREADY out 1.
- MEM_WDATA in DW; MEM_WSTRB in DW/8; MEM_WLAST in 1; MEM_WVALID in 1; MEM_WREADY out 1.
- MEM_BID out IW; MEM_BRESP out 2; MEM_BVALID out 1; MEM_BREADY in 1.
- MEM_ARID in IW; MEM_ARADDR in 32; MEM_ARLEN in 8; MEM_ARSIZE in 3; MEM_ARBURST in 2; MEM_ARVALID in 1; MEM_ARREADY out 1.
- MEM_RID out IW; MEM_RDATA out DW; MEM_RRESP out 2; MEM_RLAST out 1; MEM_RVALID out 1; MEM_RREADY in 1.

Behaviour:
- Storage: reg array i_sram.ram[0:2^AW-1], DW bits per word; byte b of a word at bits [8b+7:8b]. Word index = addr[AW+log2(DW/8)-1 : log2(DW/8)]; higher address bits are ignored, so 0x8000_0000 aliases word 0. Reset never clears the array.
- Reset: every output 0; both FSMs go to idle, including mid-burst. AWREADY/ARREADY rise in the first cycle after reset deasserts.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On AW handshake, latch id, addr, len, size, burst.
  - W_DATA: WREADY=1. Each W handshake writes the bytes whose WSTRB bits are set at the current word, then advances the address. The beat with WLAST=1 moves to W_RESP regardless of the beat count.
  - W_RESP: BVALID=1, BID=latched id, BRESP=2'b00. On BREADY, return to W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake, latch fields and load RDATA from the ram word at ARADDR.
  - First beat is valid the cycle after the AR handshake (latency 1).
  - R_DATA: RVALID=1, RID=latched id, RRESP=2'b00, RLAST=1 when beat count == len. Each R handshake advances the address and reloads RDATA at the same edge, giving back-to-back beats while RREADY=1.
  - Handshake on the RLAST beat returns to R_IDLE.
  - RDATA and RID hold while RVALID=1 and RREADY=0.
- Address advance: step = 2^size bytes.
  - INCR (01): add the step.
  - FIXED (00): no change.
  - WRAP (10): wrap within an aligned window of (len+1)*step bytes.
  - Burst 11 is treated as INCR.
- Narrow reads return the whole DW word; the master selects lanes.
- Read and write run independently in the same cycle. A read loading a word on the same edge that word is written returns the old data.
- BRESP and RRESP are always OKAY.

Optional Feature:
- Macro AXI_SRAM_WRAP_BURST_EN.
- Defined: WRAP bursts wrap as specified above.
- Undefined: WRAP (10) is treated as INCR and no wrap logic is built.

Test Plan:
- Reset then idle: after reset drops, AWREADY=1, ARREADY=1, RVALID=0, BVALID=0. Assert reset mid-burst -> RVALID/WREADY drop next cycle; ram contents unchanged.
- Single write then read: AW addr 0x8000_0010, len 0, size 4, WDATA=0x0011..FF, WSTRB all-ones -> BVALID one cycle after the W handshake, BRESP=0, BID=awid. AR to the same address -> one cycle later RVALID=1, RLAST=1, RDATA equals the written data.
- Byte strobe: WSTRB=16'h0001, WDATA low byte 0xAB, written over word 0xFFFF..FF -> read returns 0xFFFF..FFAB.
- INCR read burst: back-door ram[0..3]=1,2,3,4; AR addr 0, len 3, size 4, RREADY held 1 -> four consecutive beats 1,2,3,4, RLAST only on the 4th. Toggling RREADY -> data held while stalled.
- WRAP burst (macro on): AR addr 0x20, len 3, size 4 -> words 2,3,0,1. Macro off -> words 2,3,4,5.
- Concurrency and ID: a read burst and a write burst to different words overlapping in time -> both complete correctly. ARID 0x05 -> RID 0x05; AWID 0x0A -> BID 0x0A.
